// File: rtl/neander_pkg.sv
// Shared encodings for the Neander CPU: opcodes, ALU functions and the control FSM states.
// Used by the control unit, the datapath and the ALU.
package neander_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int ALU_W = 3;
    localparam logic [ALU_W-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALU_W-1:0] ALU_AND   = 3'd1;
    localparam logic [ALU_W-1:0] ALU_OR    = 3'd2;
    localparam logic [ALU_W-1:0] ALU_NOT   = 3'd3;
    localparam logic [ALU_W-1:0] ALU_PASSY = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_DEC  = 4'd4,
        S_AR   = 4'd5,
        S_AP   = 4'd6,
        S_LD0  = 4'd7,
        S_LD1  = 4'd8,
        S_ST0  = 4'd9,
        S_ST1  = 4'd10,
        S_JP   = 4'd11,
        S_HALT = 4'd12
    } state_t;

    // Two-byte memory-operand instructions (STA, LDA, ADD, OR, AND).
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= OP_STA) && (op <= OP_AND);
    endfunction

    function automatic logic is_jump_op(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JN) || (op == OP_JZ);
    endfunction

    // ALU function applied when the accumulator is written from memory data.
    function automatic logic [ALU_W-1:0] alu_sel(input logic [3:0] op);
        logic [ALU_W-1:0] sel;
        case (op)
            OP_ADD:  sel = ALU_ADD;
            OP_OR:   sel = ALU_OR;
            OP_AND:  sel = ALU_AND;
            OP_NOT:  sel = ALU_NOT;
            default: sel = ALU_PASSY;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/neander_ctrl.sv
// Neander control unit: fetch/decode/execute FSM driving the datapath strobes.
// Strobes decode from the state register and registered opcode/flags only.
module neander_ctrl
    import neander_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             flag_n,
    input  logic             flag_z,
    output logic             load_pc,
    output logic             inc_pc,
    output logic             sel_rem,
    output logic             load_rem,
    output logic             load_rdm,
    output logic             sel_rdm,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             load_ri,
    output logic             load_ac,
    output logic             load_nz,
    output logic [ALU_W-1:0] alu_op,
    output logic             halted,
    output logic             busy
);

    state_t state_r;
    state_t next_state_s;
    logic   jump_taken_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    assign jump_taken_s = (opcode == OP_JMP) ||
                          ((opcode == OP_JN) && flag_n) ||
                          ((opcode == OP_JZ) && flag_z);

    // Next-state and strobe decode.
    always_comb begin
        next_state_s = state_r;
        load_pc  = 1'b0;
        inc_pc   = 1'b0;
        sel_rem  = 1'b0;
        load_rem = 1'b0;
        load_rdm = 1'b0;
        sel_rdm  = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        load_ri  = 1'b0;
        load_ac  = 1'b0;
        load_nz  = 1'b0;
        alu_op   = ALU_ADD;
        halted   = 1'b0;
        busy     = 1'b1;
        case (state_r)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state_s = S_F0;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_F0: begin
                load_rem     = 1'b1;
                next_state_s = S_F1;
            end
            S_F1: begin
                mem_rd       = 1'b1;
                load_rdm     = 1'b1;
                inc_pc       = 1'b1;
                next_state_s = S_F2;
            end
            S_F2: begin
                load_ri      = 1'b1;
                next_state_s = S_DEC;
            end
            S_DEC: begin
                if (opcode == OP_HLT) begin
                    next_state_s = S_HALT;
                end else if (opcode == OP_NOT) begin
                    load_ac      = 1'b1;
                    load_nz      = 1'b1;
                    alu_op       = ALU_NOT;
                    next_state_s = S_F0;
                end else if (is_mem_op(opcode) || (is_jump_op(opcode) && jump_taken_s)) begin
                    load_rem     = 1'b1;
                    next_state_s = S_AR;
                end else if (is_jump_op(opcode)) begin
                    // Untaken jump still has to step over its operand byte.
                    inc_pc       = 1'b1;
                    next_state_s = S_F0;
                end else begin
                    next_state_s = S_F0;
                end
            end
            S_AR: begin
                mem_rd   = 1'b1;
                load_rdm = 1'b1;
                if (is_jump_op(opcode)) begin
                    next_state_s = S_JP;
                end else begin
                    inc_pc       = 1'b1;
                    next_state_s = S_AP;
                end
            end
            S_AP: begin
                sel_rem  = 1'b1;
                load_rem = 1'b1;
                if (opcode == OP_STA) begin
                    next_state_s = S_ST0;
                end else begin
                    next_state_s = S_LD0;
                end
            end
            S_LD0: begin
                mem_rd       = 1'b1;
                load_rdm     = 1'b1;
                next_state_s = S_LD1;
            end
            S_LD1: begin
                load_ac      = 1'b1;
                load_nz      = 1'b1;
                alu_op       = alu_sel(opcode);
                next_state_s = S_F0;
            end
            S_ST0: begin
                sel_rdm      = 1'b1;
                load_rdm     = 1'b1;
                next_state_s = S_ST1;
            end
            S_ST1: begin
                mem_wr       = 1'b1;
                next_state_s = S_F0;
            end
            S_JP: begin
                load_pc      = 1'b1;
                next_state_s = S_F0;
            end
            S_HALT: begin
                halted       = 1'b1;
                busy         = 1'b0;
                next_state_s = S_HALT;
            end
            default: begin
                busy         = 1'b0;
                next_state_s = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/neander_ctrl.md
# neander_ctrl

Control unit for the 8-bit Neander accumulator CPU. A single-clock FSM that fetches, decodes and executes one instruction at a time by driving the load, increment and select strobes of the datapath: PC, the PC/RDM address mux in front of REM, REM, RDM, RI, AC, NZ flags, ALU and memory. It sits beside the datapath and is the only block that sequences it.

## Interface
Parameters:
- none. Opcode, ALU-op and state encodings come from the shared package.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; leaves IDLE and begins fetch at the current PC
- opcode  in  4  RI[7:4], registered in the datapath
- flag_n  in  1  N flag register
- flag_z  in  1  Z flag register
- load_pc  out  1  PC <= RDM
- inc_pc  out  1  PC <= PC+1, mod 256
- sel_rem  out  1  address mux select: 0 = PC, 1 = RDM
- load_rem  out  1  REM <= mux output
- load_rdm  out  1  RDM <= selected source
- sel_rdm  out  1  RDM source: 0 = memory read data, 1 = AC
- mem_rd  out  1  memory read at REM; data is combinational and valid in the same cycle
- mem_wr  out  1  memory write of RDM at REM, committed at the clock edge
- load_ri  out  1  RI <= RDM
- load_ac  out  1  AC <= ALU result
- load_nz  out  1  N/Z <= flags of the ALU result
- alu_op  out  3  ALU function
- halted  out  1  high in HALT
- busy  out  1  high in every state except IDLE and HALT

## Operation
- Opcodes: 0 NOP, 1 STA, 2 LDA, 3 ADD, 4 OR, 5 AND, 6 NOT, 8 JMP, 9 JN, A JZ, F HLT. Opcodes 7, B–E execute as NOP.
- alu_op: 0 ADD, 1 AND, 2 OR, 3 NOT, 4 PASSY for LDA. It is 0 whenever load_ac is low.
- States and their asserted outputs. Every output not listed is 0.
  - IDLE: if start, go to F0.
  - F0: sel_rem=0, load_rem. Go to F1.
  - F1: mem_rd, load_rdm, inc_pc. Go to F2.
  - F2: load_ri. Go to DEC.
  - DEC, NOP or unused opcode: go to F0.
  - DEC, NOT: load_ac, load_nz, alu_op=NOT. Go to F0.
  - DEC, HLT: go to HALT.
  - DEC, STA, LDA, ADD, OR or AND: sel_rem=0, load_rem. Go to AR.
  - DEC, jump taken (JMP always, JN if flag_n, JZ if flag_z): sel_rem=0, load_rem. Go to AR.
  - DEC, jump not taken: inc_pc to skip the operand. Go to F0.
  - AR: mem_rd, load_rdm. Also inc_pc for non-jump opcodes. Go to JP for jumps, else AP.
  - AP: sel_rem=1, load_rem. Go to ST0 for STA, else LD0.
  - LD0: mem_rd, load_rdm. Go to LD1.
  - LD1: load_ac, load_nz, alu_op for the opcode. Go to F0.
  - ST0: sel_rdm=1, load_rdm. Go to ST1.
  - ST1: mem_wr. Go to F0.
  - JP: load_pc. Go to F0.
  - HALT: halted=1. Stays here until rst_n. start is ignored.
- start is ignored in every state except IDLE.
- Outputs are combinational from the state register plus opcode, flag_n and flag_z. All of these sources are registers, so no input-to-output path exists outside DEC.
- Flags are sampled only in DEC.

## Timing
- Reset values: state IDLE; all outputs 0, including halted and busy.
- Reset asserted mid-instruction: the FSM returns to IDLE immediately and all strobes drop. Any partial write not yet clocked is discarded.
- Cycles per instruction, counted from F0:
  - NOP, NOT, HLT, jump not taken: 4
  - JMP or jump taken: 6
  - LDA, ADD, OR, AND, STA: 8
- PC advances by exactly 2 for two-byte instructions and for untaken jumps. It advances by 1 for NOP, NOT and HLT.
- PC wraps from 0xFF to 0x00 with no special handling.
- Back-to-back instructions: F0 follows the last cycle of the previous instruction with no bubble.

## Structure
- Package neander_pkg holds:
  - opcode localparams (OP_NOP … OP_HLT)
  - ALU_ADD/AND/OR/NOT/PASSY with a 3-bit width constant
  - the state enum
- One module containing the state register and a single output/next-state decode block. No sub-module is needed.
- neander_pkg is shared with the datapath and ALU.

## Test plan
- Reset, then start=1 for one cycle: busy rises the next cycle. F0 shows sel_rem=0 and load_rem=1; F1 shows mem_rd, load_rdm and inc_pc together.
- Opcode 2 (LDA): exactly 8 busy cycles from F0. LD1 shows load_ac=1, load_nz=1, alu_op=4. inc_pc is asserted twice in total.
- Opcode 1 (STA): ST0 shows sel_rdm=1 with load_rdm. ST1 shows a single mem_wr. Any cycle with mem_wr high and load_ac high at the same time is a failure.
- Opcode 9 (JN) with flag_n=1: load_pc in cycle 6 and no inc_pc in AR. Same with flag_n=0: inc_pc in DEC and the next F0 at cycle 5.
- Opcode F (HLT): halted=1 and busy=0 from cycle 5. A later start pulse leaves halted=1. Then rst_n=0 clears halted asynchronously.
- Reset asserted during LD0 of an ADD: all outputs 0 immediately. After release the FSM stays in IDLE until a start pulse.
